// File: rtl/utm_tape_unit.sv
// utm_tape_unit: tape store and head controller for the universal Turing machine.
//
// Holds the tape as an array of symbol cells and presents the symbol under the
// head to the combinational next-state block. In RUN it applies that block's
// action (write, move, halt) once per enabled clock.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   clear              synchronous: zero tape, head to 0, back to IDLE
//   load_en, load_sym  IDLE only: write load_sym at head, then head+1
//   start              IDLE only: head to 0, steps/wrapped cleared, enter RUN
//   step_en            RUN only: apply act_* this cycle
//   act_sym, act_dir,  action from the next-state block
//   act_halt
//   sym                tape[head], muxed from cell flops
//   head               current head position
//   running, halted    decoded from registered state
//   wrapped            sticky: head crossed a tape end during RUN
//   steps              saturating count of applied non-halt steps
module utm_tape_unit #(
    parameter int unsigned TAPE_LEN = 16,
    parameter int unsigned SYM_W    = 3,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned HEAD_W  = $clog2(TAPE_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_en,
    input  logic [SYM_W-1:0]  load_sym,
    input  logic              start,
    input  logic              step_en,
    input  logic [SYM_W-1:0]  act_sym,
    input  logic              act_dir,
    input  logic              act_halt,
    output logic [SYM_W-1:0]  sym,
    output logic [HEAD_W-1:0] head,
    output logic              running,
    output logic              halted,
    output logic              wrapped,
    output logic [CNT_W-1:0]  steps
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic [SYM_W-1:0]  tape_q [TAPE_LEN];
    logic [HEAD_W-1:0] head_q, head_d;
    logic [CNT_W-1:0]  steps_q, steps_d;
    logic              wrapped_q, wrapped_d;

    // Single write port into the tape, shared by load and run-step writes.
    logic              wr_en;
    logic [SYM_W-1:0]  wr_sym;
    logic              tape_clr;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        steps_d   = steps_q;
        wrapped_d = wrapped_q;
        wr_en     = 1'b0;
        wr_sym    = act_sym;
        tape_clr  = 1'b0;

        if (clear) begin
            tape_clr  = 1'b1;
            head_d    = '0;
            steps_d   = '0;
            wrapped_d = 1'b0;
            state_d   = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        head_d    = '0;
                        steps_d   = '0;
                        wrapped_d = 1'b0;
                        state_d   = StRun;
                    end else if (load_en) begin
                        wr_en  = 1'b1;
                        wr_sym = load_sym;
                        // Power-of-two length: natural overflow is the modulo wrap.
                        head_d = head_q + HEAD_W'(1);
                    end
                end
                StRun: begin
                    if (step_en) begin
                        if (act_halt) begin
                            state_d = StHalted;
                        end else begin
                            wr_en  = 1'b1;
                            wr_sym = act_sym;
                            if (act_dir) begin
                                head_d = head_q + HEAD_W'(1);
                                if (head_q == '1) wrapped_d = 1'b1;
                            end else begin
                                head_d = head_q - HEAD_W'(1);
                                if (head_q == '0) wrapped_d = 1'b1;
                            end
                            if (steps_q != '1) steps_d = steps_q + CNT_W'(1);
                        end
                    end
                end
                default: ; // StHalted holds everything until clear
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            head_q    <= '0;
            steps_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            steps_q   <= steps_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAPE_LEN); i++) tape_q[i] <= '0;
        end else if (tape_clr) begin
            for (int i = 0; i < int'(TAPE_LEN); i++) tape_q[i] <= '0;
        end else if (wr_en) begin
            tape_q[head_q] <= wr_sym;
        end
    end

    assign sym     = tape_q[head_q];
    assign head    = head_q;
    assign running = (state_q == StRun);
    assign halted  = (state_q == StHalted);
    assign wrapped = wrapped_q;
    assign steps   = steps_q;

endmodule

// File: doc/utm_tape_unit.md
Name: utm_tape_unit

Overview:
- Tape store and head controller for the universal Turing machine.
- Holds the tape as an array of symbol cells and presents the symbol under the head to the combinational next-state block.
- Consumes that block's action (write symbol, move direction, halt) and applies it one step per enabled clock.
- Sits directly around the next-state logic: feeds its symbol inputs and takes its action outputs.

Parameters:
TAPE_LEN, 16, number of tape cells; power of two, minimum 4
SYM_W, 3, bits per tape symbol; matches the next-state symbol inputs s2..s0
CNT_W, 8, width of the step counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous: zero the tape, head to 0, return to IDLE
load_en  input  1  in IDLE, write load_sym at head, then head+1
load_sym  input  SYM_W  symbol for load
start  input  1  in IDLE, head to 0, enter RUN
step_en  input  1  in RUN, apply one action this cycle
act_sym  input  SYM_W  symbol to write at head (from next-state block)
act_dir  input  1  head move after write: 1 = right (+1), 0 = left (-1)
act_halt  input  1  halt action; write and move are suppressed
sym  output  SYM_W  tape[head], combinational from cell flops
head  output  log2(TAPE_LEN)  current head position
running  output  1  high in RUN
halted  output  1  high in HALTED
wrapped  output  1  sticky; head crossed a tape end during RUN
steps  output  CNT_W  count of applied non-halt steps, saturating

Behaviour:
- Reset (async, rst_n=0): all cells 0, head=0, state IDLE, steps=0, wrapped=0, running=0, halted=0. sym therefore reads 0.
- States: IDLE, RUN, HALTED. Command priority is clear > start > load_en; step_en is only used in RUN.
- clear (any state): all cells 0, head=0, steps=0, wrapped=0, state goes to IDLE next cycle.
- IDLE + start: head=0, steps=0, wrapped=0, state goes to RUN. Tape contents are kept. A load_en in the same cycle is ignored.
- IDLE + load_en (start=0): tape[head] <= load_sym and head <= head+1 modulo TAPE_LEN. No wrapped flag is set in IDLE.
- load_en outside IDLE is ignored. start outside IDLE is ignored.
- RUN + step_en, act_halt=0, applied in one edge:
  - tape[head] <= act_sym
  - head moves by act_dir
  - steps <= steps+1, saturating at 2^CNT_W-1
  - sym reflects the new head and tape on the next cycle, so there is one step per cycle with zero extra latency.
- RUN + step_en + act_halt=1: no write, no move, steps unchanged, state goes to HALTED.
- RUN with step_en=0: everything holds.
- Head wrap in RUN:
  - right from TAPE_LEN-1 goes to 0, and wrapped is set.
  - left from 0 goes to TAPE_LEN-1, and wrapped is set.
  - The wrap still takes place; wrapped only flags it.
- HALTED: all state holds, halted=1. The only exit is clear, then start after it.
- Outputs running and halted are decoded from registered state (glitch-free). sym is the mux of registered cells.
- Reset asserted mid-RUN: immediate return to reset values, with no partial write.

Test Plan:
- Reset then load_en x4 with 1,2,3,4 -> head=4, tape[0..3]=1,2,3,4; after start, head=0 and sym=1.
- RUN, step_en with act_sym=5, act_dir=1 -> next cycle tape[0]=5, head=1, sym=2, steps=1.
- RUN at head=0, step act_dir=0 -> head=15, wrapped=1; then a step with act_dir=1 -> head=0 and wrapped stays 1.
- Step with act_halt=1 and act_sym=7 -> halted=1, running=0, tape[head] unchanged, steps unchanged; later step_en and load_en have no effect.
- 300 non-halt steps with CNT_W=8 -> steps=255 (saturated).
- start and load_en together in IDLE -> RUN entered and no write. clear with start -> IDLE and tape all 0. rst_n pulsed mid-step -> all reset values.
